// File: rtl/lfsr_step_reg.sv
// lfsr_step_reg
//   WIDTH-bit state register with parallel load, serial shift and Fibonacci
//   LFSR step modes, plus period measurement of the stepped sequence.
//
//   Optional feature macro: LFSR_LOCKUP_RECOVER_EN
//     defined   -> a step attempted from the all-zero state reloads SEED and
//                  pulses lockup for one cycle
//     undefined -> the all-zero state is sticky under stepping; lockup is 0
//
// Ports
//   clk_in      rising-edge clock
//   rst_n       asynchronous active-low reset
//   load        parallel load strobe (highest priority, ignores en)
//   in          parallel load data
//   en          enables the operation selected by mode
//   mode        00 hold, 01 shift, 10 LFSR step, 11 hold
//   ser_in      serial input bit for shift mode
//   q_out       state register
//   serial_out  q_out MSB, combinational
//   wrap        one-cycle pulse when a step returns to the start value
//   period_out  step count of the last completed cycle
//   lockup      one-cycle pulse when all-zero recovery fires
module lfsr_step_reg #(
   parameter int unsigned       WIDTH = 8,
   parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0]  SEED  = WIDTH'(1)
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             ser_in,
   output logic [WIDTH-1:0] q_out,
   output logic             serial_out,
   output logic             wrap,
   output logic [WIDTH-1:0] period_out,
   output logic             lockup
);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_SHIFT = 2'b01,
      MODE_STEP  = 2'b10,
      MODE_IDLE  = 2'b11
   } mode_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   mode_t            mode_sel;
   logic             fb;
   logic [WIDTH-1:0] shift_nxt;
   logic [WIDTH-1:0] step_nxt;
   logic [WIDTH-1:0] start;
   logic [WIDTH-1:0] cnt;

   always_comb begin
      mode_sel  = mode_t'(mode);
      fb        = ^(q_out & TAPS);
      shift_nxt = {q_out[WIDTH-2:0], ser_in};
      step_nxt  = {q_out[WIDTH-2:0], fb};
   end

   assign serial_out = q_out[WIDTH-1];

`ifdef LFSR_LOCKUP_RECOVER_EN
   logic lockup_r;
   assign lockup = lockup_r;
`else
   assign lockup = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         q_out      <= SEED;
         start      <= SEED;
         cnt        <= '0;
         period_out <= '0;
         wrap       <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
         lockup_r   <= 1'b0;
`endif
      end else begin
         wrap     <= 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
         lockup_r <= 1'b0;
`endif
         if (load) begin
            q_out <= in;
            start <= in;
            cnt   <= '0;
         end else if (en) begin
            case (mode_sel)
               MODE_SHIFT: begin
                  // Shifting redefines the sequence, so tracking restarts here.
                  q_out <= shift_nxt;
                  start <= shift_nxt;
                  cnt   <= '0;
               end
               MODE_STEP: begin
                  if (q_out != '0) begin
                     q_out <= step_nxt;
                     if (step_nxt == start) begin
                        wrap       <= 1'b1;
                        period_out <= cnt + ONE;
                        cnt        <= '0;
                     end else begin
                        cnt <= cnt + ONE;
                     end
                  end
`ifdef LFSR_LOCKUP_RECOVER_EN
                  else begin
                     q_out    <= SEED;
                     start    <= SEED;
                     cnt      <= '0;
                     lockup_r <= 1'b1;
                  end
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule
